// File: rtl/xc_aessub_arb.sv
// xc_aessub_arb
//   Shares a single xc_aessub SubBytes unit between two requesters (port 0,
//   e.g. scalar issue; port 1, e.g. the key-schedule engine). One requester is
//   granted at a time. The grant is held until the unit completes, and the
//   result goes back to that requester only. The unit is flushed on every
//   completion so that a multi-cycle unit restarts from byte 0.
//
//   FAIR = 1 : round-robin when both ports request together.
//   FAIR = 0 : fixed priority, where port 0 always wins.
//
//   Build option XC_AESSUB_ARB_PERF_EN adds 32-bit completion and
//   contention-stall counters. Without it, perf_ops and perf_stall read 0 and
//   no counter flops are built.

module xc_aessub_arb #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,

    // Requester port 0
    input  logic        req0_valid,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic        req0_enc,
    input  logic        req0_rot,
    output logic        req0_ready,

    // Requester port 1
    input  logic        req1_valid,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    input  logic        req1_enc,
    input  logic        req1_rot,
    output logic        req1_ready,

    // Shared result, qualified by req0_ready / req1_ready
    output logic [31:0] req_result,

    // Shared SubBytes unit
    output logic        sub_valid,
    output logic [31:0] sub_rs1,
    output logic [31:0] sub_rs2,
    output logic        sub_enc,
    output logic        sub_rot,
    output logic        sub_flush,
    input  logic        sub_ready,
    input  logic [31:0] sub_result,

    // Performance counters (zero unless XC_AESSUB_ARB_PERF_EN)
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       owner_q;    // port holding the unit while BUSY
    logic       owner_d;
    logic       last_q;     // port that completed most recently
    logic       last_d;
    logic       winner;     // port whose operands drive the unit this cycle
    logic       any_req;
    logic       complete;

    assign any_req = req0_valid || req1_valid;

    // Select the port presented to the unit: live arbitration in IDLE, held owner in BUSY
    always_comb begin
        // NOTE: assign a default before any branch. Without it, a path that skips
        // the assignment makes synthesis infer a latch.
        winner = owner_q;
        if (state_q == STATE_IDLE) begin
            if (req0_valid && req1_valid) begin
                winner = FAIR ? ~last_q : 1'b0;
            end else begin
                winner = req1_valid;
            end
        end
    end

    // Drive the unit from the selected port; a flush or reset withholds valid
    always_comb begin
        sub_valid = !reset && !flush && ((state_q == STATE_BUSY) || any_req);
        sub_rs1   = winner ? req1_rs1 : req0_rs1;
        sub_rs2   = winner ? req1_rs2 : req0_rs2;
        sub_enc   = winner ? req1_enc : req0_enc;
        sub_rot   = winner ? req1_rot : req0_rot;
    end

    assign complete = sub_valid && sub_ready;

    // Return the result to the winner only, and restart the unit after every
    // completion, flush or reset
    always_comb begin
        req0_ready = complete && !winner;
        req1_ready = complete &&  winner;
        req_result = sub_result;
        sub_flush  = reset || flush || complete;
    end

    // Next-state logic. A flush aborts without touching the round-robin pointer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (flush) begin
            state_d = STATE_IDLE;
        end else if (complete) begin
            state_d = STATE_IDLE;
            last_d  = winner;
        end else if ((state_q == STATE_IDLE) && sub_valid) begin
            state_d = STATE_BUSY;
            owner_d = winner;
        end
    end

    // Arbiter state registers; last resets to 1 so port 0 wins the first contest
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples the values from before the clock edge.
        if (reset) begin
            state_q <= STATE_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef XC_AESSUB_ARB_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stall_q;
    logic        stall0;
    logic        stall1;

    // A port stalls when it requests but is not the one driving the unit
    assign stall0 = req0_valid && !(sub_valid && !winner);
    assign stall1 = req1_valid && !(sub_valid &&  winner);

    // Completion and contention counters; they wrap and survive flush
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (complete) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (stall0 || stall1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_ops   = '0;
    assign perf_stall = '0;
`endif

endmodule
